// File: rtl/mips_muldiv_unit.sv
// Iterative signed MULT/DIV unit owning the HI/LO registers, with MTHI/MTLO moves.
// Define MULDIV_FAST_MULT_EN to compute MULT in one registered cycle instead of shift-add.
module mips_muldiv_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int HI_LO_SEL_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hi_write,
  input  logic                       lo_write,
  input  logic [HI_LO_SEL_WIDTH-1:0] hi_select,
  input  logic [HI_LO_SEL_WIDTH-1:0] lo_select,
  input  logic [DATA_WIDTH-1:0]      rs_data,
  input  logic [DATA_WIDTH-1:0]      rt_data,
  output logic [DATA_WIDTH-1:0]      hi,
  output logic [DATA_WIDTH-1:0]      lo,
  output logic                       busy,
  output logic                       done,
  output logic                       div_zero
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [HI_LO_SEL_WIDTH-1:0] SEL_MOVE = HI_LO_SEL_WIDTH'(1);
  localparam logic [HI_LO_SEL_WIDTH-1:0] SEL_DIV  = HI_LO_SEL_WIDTH'(2);
  localparam logic [HI_LO_SEL_WIDTH-1:0] SEL_MULT = HI_LO_SEL_WIDTH'(3);
  localparam logic [CNT_W-1:0]           CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [W-1:0]     a_mag;
  logic [W-1:0]     b_mag;
  logic             neg_a;
  logic             neg_b;
  logic             is_div;
  // Upper half: MUL partial product / DIV remainder; lower half: multiplier / quotient.
  logic [2*W-1:0]   acc;

  logic             start_ok;
  logic [W-1:0]     rs_abs;
  logic [W-1:0]     rt_abs;
  logic [W:0]       div_shift;
  logic [W:0]       div_diff;
  logic [2*W-1:0]   div_next;
  logic [W-1:0]     fix_hi;
  logic [W-1:0]     fix_lo;

  assign start_ok = !busy && hi_write && lo_write && (hi_select == lo_select) &&
                    ((hi_select == SEL_DIV) || (hi_select == SEL_MULT));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rs_abs    = rs_data[W-1] ? -rs_data : rs_data;
    rt_abs    = rt_data[W-1] ? -rt_data : rt_data;
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    div_next  = div_diff[W] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                            : {div_diff[W-1:0],  acc[W-2:0], 1'b1};
    fix_hi    = '0;
    fix_lo    = '0;
    if (is_div) begin
      if (div_zero) begin
        fix_lo = '1;
        fix_hi = neg_a ? -a_mag : a_mag;
      end else begin
        fix_lo = (neg_a ^ neg_b) ? -acc[W-1:0] : acc[W-1:0];
        fix_hi = neg_a ? -acc[2*W-1:W] : acc[2*W-1:W];
      end
    end else begin
      {fix_hi, fix_lo} = (neg_a ^ neg_b) ? -acc : acc;
    end
  end

`ifndef MULDIV_FAST_MULT_EN
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_mag} : '0);
    mul_next = {mul_sum, acc[W-1:1]};
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      is_div   <= 1'b0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            a_mag  <= rs_abs;
            b_mag  <= rt_abs;
            neg_a  <= rs_data[W-1];
            neg_b  <= rt_data[W-1];
            count  <= '0;
            busy   <= 1'b1;
            is_div <= (hi_select == SEL_DIV);
            if (hi_select == SEL_DIV) begin
              acc      <= {{W{1'b0}}, rs_abs};
              div_zero <= (rt_data == '0);
              state    <= ST_DIV;
            end else begin
`ifdef MULDIV_FAST_MULT_EN
              acc   <= {{W{1'b0}}, rs_abs} * {{W{1'b0}}, rt_abs};
              state <= ST_FIX;
`else
              acc   <= {{W{1'b0}}, rt_abs};
              state <= ST_MUL;
`endif
            end
          end else begin
            if (hi_write && (hi_select == SEL_MOVE)) hi <= rs_data;
            if (lo_write && (lo_select == SEL_MOVE)) lo <= rs_data;
          end
        end
`ifndef MULDIV_FAST_MULT_EN
        ST_MUL: begin
          acc   <= mul_next;
          count <= count + CNT_W'(1);
          if (count == CNT_LAST) state <= ST_FIX;
        end
`endif
        ST_DIV: begin
          acc   <= div_next;
          count <= count + CNT_W'(1);
          if (count == CNT_LAST) state <= ST_FIX;
        end
        ST_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
